// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_W_DEF = 11;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/pwm_deadtime.sv
// One channel of dead-time insertion: a complementary pair with both sides
// held low for dt cycles after every edge of the raw compare result.
module pwm_deadtime #(
    parameter int unsigned DT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            hi,
    output logic            lo
);

    logic            raw_prev_q;
    logic [DT_W-1:0] timer_q;
    logic [DT_W-1:0] timer_d;
    logic            hi_d;
    logic            lo_d;
    logic            edge_c;

    // Any raw edge (re)arms the timer; the new side is driven once it expires.
    always_comb begin
        timer_d = '0;
        hi_d    = 1'b0;
        lo_d    = 1'b0;
        edge_c  = raw != raw_prev_q;
        if (!en) begin
            timer_d = '0;
        end else if (edge_c && (dt != '0)) begin
            timer_d = dt;
        end else if (timer_q > DT_W'(1)) begin
            timer_d = timer_q - DT_W'(1);
        end else begin
            hi_d = raw;
            lo_d = !raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_q <= 1'b0;
            timer_q    <= '0;
            hi         <= 1'b0;
            lo         <= 1'b0;
        end else begin
            raw_prev_q <= raw;
            timer_q    <= timer_d;
            hi         <= hi_d;
            lo         <= lo_d;
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: one shared period counter (edge or center aligned) with
// NCH comparators and boundary-synchronised shadow registers.
// Optional dead-time pairs are enabled with `define PWM_DEADTIME_EN.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int unsigned W    = PWM_W_DEF,
    parameter int unsigned NCH  = 4,
    parameter int unsigned DT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [W-1:0]       period_in,
    input  logic [NCH*W-1:0]   duty_in,
    input  logic               center_in,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]    dt_in,
    output logic [NCH-1:0]     pwm_n_out,
`endif
    output logic [NCH-1:0]     pwm_out,
    output logic               cycle_start,
    output logic               pending
);

    if (DT_W == 0) begin : g_dt_w_check
        $error("pwm_multi_gen: DT_W must be nonzero");
    end

    logic [W-1:0]          cnt_q;
    logic [W-1:0]          cnt_d;
    cnt_dir_e              dir_q;
    cnt_dir_e              dir_d;

    logic [W-1:0]          period_q;
    logic [W-1:0]          period_s;
    logic [NCH-1:0][W-1:0] duty_q;
    logic [NCH-1:0][W-1:0] duty_s;
    pwm_mode_e             mode_q;
    pwm_mode_e             mode_s;

    logic                  tick_c;
    logic                  apply_c;
    logic                  cs_c;
    logic [NCH-1:0]        raw_c;

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Next count: every boundary (and idle) restarts the period at 0 going up.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en || tick_c) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_q == PWM_EDGE) begin
            cnt_d = cnt_q + W'(1);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == period_q) begin
                cnt_d = cnt_q - W'(1);
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Boundary detection, shadow apply decision and comparators
    always_comb begin
        tick_c  = 1'b0;
        apply_c = 1'b0;
        cs_c    = 1'b0;
        raw_c   = '0;
        if (mode_q == PWM_EDGE) begin
            tick_c = cnt_q == period_q;
        end else begin
            tick_c = ((dir_q == DIR_DOWN) && (cnt_q == W'(1))) ||
                     ((dir_q == DIR_UP) && (cnt_q == period_q) && (period_q <= W'(1)));
        end
        apply_c = pending && !load && (!en || tick_c);
        cs_c    = en && (cnt_q == '0) && (dir_q == DIR_UP);
        for (int unsigned i = 0; i < NCH; i++) begin
            raw_c[i] = cnt_q < duty_q[i];
        end
    end

    // Shadow capture and active update; a load always wins over an apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '1;
            period_s <= '1;
            duty_q   <= '0;
            duty_s   <= '0;
            mode_q   <= PWM_EDGE;
            mode_s   <= PWM_EDGE;
            pending  <= 1'b0;
        end else if (load) begin
            period_s <= period_in;
            duty_s   <= duty_in;
            mode_s   <= center_in ? PWM_CENTER : PWM_EDGE;
            pending  <= 1'b1;
        end else if (apply_c) begin
            period_q <= period_s;
            duty_q   <= duty_s;
            mode_q   <= mode_s;
            pending  <= 1'b0;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [NCH-1:0] raw_q;
    logic           cs_q;
    logic           en_q;

    // Extra stage so the dead-time units see an en aligned with raw_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q       <= '0;
            cs_q        <= 1'b0;
            en_q        <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            raw_q       <= en ? raw_c : '0;
            cs_q        <= cs_c;
            en_q        <= en;
            cycle_start <= cs_q;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_dt
        pwm_deadtime #(
            .DT_W (DT_W)
        ) u_dt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en_q),
            .raw   (raw_q[g]),
            .dt    (dt_in),
            .hi    (pwm_out[g]),
            .lo    (pwm_n_out[g])
        );
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            cycle_start <= 1'b0;
        end else begin
            pwm_out     <= en ? raw_c : '0;
            cycle_start <= cs_c;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen; covers the PWM_DEADTIME_EN build as well.
module tb_pwm_multi_gen;
    import pwm_pkg::*;

    localparam int unsigned W    = 11;
    localparam int unsigned NCH  = 4;
    localparam int unsigned DT_W = 6;
`ifdef PWM_DEADTIME_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               load;
    logic [W-1:0]       period_in;
    logic [NCH*W-1:0]   duty_in;
    logic               center_in;
    logic [NCH-1:0]     pwm_out;
    logic               cycle_start;
    logic               pending;
`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0]    dt_in;
    logic [NCH-1:0]     pwm_n_out;
`endif

    pwm_multi_gen #(.W(W), .NCH(NCH), .DT_W(DT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .center_in   (center_in),
`ifdef PWM_DEADTIME_EN
        .dt_in       (dt_in),
        .pwm_n_out   (pwm_n_out),
`endif
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic           cs;
    } exp_t;

    exp_t q_out[$];
    logic q_pend[$];

    int checks = 0;
    int errors = 0;

    // Reference state as the spec describes it
    logic [W-1:0] cnt_m, per_m, sh_per;
    logic         dir_m, ctr_m, sh_ctr, pend_m;
    logic [W-1:0] duty_m [NCH];
    logic [W-1:0] sh_duty [NCH];

    bit pwm_chk_en = 1'b1;
    int hi_cnt [NCH];
    int cs_cnt;
    int n_cnt;
    int both_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cnt_m  = '0; dir_m = 1'b0; per_m = '1; ctr_m = 1'b0;
        sh_per = '1; sh_ctr = 1'b0; pend_m = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            duty_m[i]  = '0;
            sh_duty[i] = '0;
        end
        q_out.delete();
        q_pend.delete();
    endtask

    // Predict the registered outputs for the coming clock edge and advance.
    task automatic model_step();
        exp_t e;
        logic tick, apply;
        for (int i = 0; i < NCH; i++) e.pwm[i] = en && (cnt_m < duty_m[i]);
        e.cs = en && (cnt_m == 0) && !dir_m;
        if (ctr_m) tick = (dir_m && cnt_m == 1) || (!dir_m && cnt_m == per_m && per_m <= 1);
        else       tick = (cnt_m == per_m);
        apply = pend_m && !load && (!en || tick);
        if (!en || tick) begin
            cnt_m = '0; dir_m = 1'b0;
        end else if (!ctr_m || !dir_m) begin
            if (ctr_m && cnt_m == per_m) begin
                dir_m = 1'b1; cnt_m = cnt_m - 1'b1;
            end else begin
                cnt_m = cnt_m + 1'b1;
            end
        end else begin
            cnt_m = cnt_m - 1'b1;
        end
        if (load) begin
            sh_per = period_in; sh_ctr = center_in; pend_m = 1'b1;
            for (int i = 0; i < NCH; i++) sh_duty[i] = duty_in[i*W +: W];
        end else if (apply) begin
            per_m = sh_per; ctr_m = sh_ctr; pend_m = 1'b0;
            for (int i = 0; i < NCH; i++) duty_m[i] = sh_duty[i];
        end
        q_out.push_back(e);
        q_pend.push_back(pend_m);
    endtask

    task automatic clr_acc();
        for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
        cs_cnt = 0; n_cnt = 0; both_low = 0;
    endtask

    // One clock: predict, wait for the falling edge, compare, accumulate.
    task automatic cycle();
        exp_t e;
        model_step();
        @(negedge clk);
        if (q_pend.size() > 0) chk("pending", 32'(pending), 32'(q_pend.pop_front()));
        if (q_out.size() == LAT) begin
            e = q_out.pop_front();
            if (pwm_chk_en) chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
            chk("cycle_start", 32'(cycle_start), 32'(e.cs));
        end
        for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
        cs_cnt += int'(cycle_start);
`ifdef PWM_DEADTIME_EN
        n_cnt    += int'(pwm_n_out[0]);
        both_low += int'(!pwm_out[0] && !pwm_n_out[0]);
`endif
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_cnt(input logic [W-1:0] val);
        for (int k = 0; k < 64 && cnt_m != val; k++) cycle();
        chk("wait_cnt", 32'(cnt_m), 32'(val));
    endtask

    task automatic set_duty(input int d3, input int d2, input int d1, input int d0);
        duty_in = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        period_in = '0; duty_in = '0; center_in = 1'b0;
`ifdef PWM_DEADTIME_EN
        dt_in = '0;
`endif
        model_reset();
        clr_acc();
        #2;
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_cs", 32'(cycle_start), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge mode P=9, duty {0,3,10,5}; applied while idle
        period_in = W'(9); center_in = 1'b0; set_duty(5, 10, 3, 0);
        load = 1'b1; cycle(); load = 1'b0;
        cycle();
        chk("idle_apply", 32'(pending), 32'h0);
        en = 1'b1;
        run(12); clr_acc(); run(20);
        chk("edge_ch0_hi", 32'(hi_cnt[0]), 32'd0);
        chk("edge_ch1_hi", 32'(hi_cnt[1]), 32'd6);
        chk("edge_ch2_hi", 32'(hi_cnt[2]), 32'd20);
        chk("edge_ch3_hi", 32'(hi_cnt[3]), 32'd10);
        chk("edge_cs", 32'(cs_cnt), 32'd2);

        // Mid-period load of duty[0]=7
        wait_cnt(W'(4));
        set_duty(5, 10, 3, 7);
        load = 1'b1; cycle(); load = 1'b0;
        chk("mid_pending", 32'(pending), 32'h1);
        run(20); clr_acc(); run(20);
        chk("mid_ch0_hi", 32'(hi_cnt[0]), 32'd14);

        // Load then en low: applied on the next cycle without a boundary
        wait_cnt(W'(3));
        set_duty(6, 10, 3, 7);
        load = 1'b1; cycle(); load = 1'b0;
        en = 1'b0; cycle();
        chk("en_low_pending", 32'(pending), 32'h0);
`ifndef PWM_DEADTIME_EN
        chk("en_low_pwm", 32'(pwm_out), 32'h0);
`endif
        run(3); en = 1'b1;
        run(12); clr_acc(); run(20);
        chk("en_ch3_hi", 32'(hi_cnt[3]), 32'd12);

        // Load on the boundary tick defers the shrink to the following period
        wait_cnt(W'(9));
        period_in = W'(2);
        load = 1'b1; cycle(); load = 1'b0;
        chk("tick_pending", 32'(pending), 32'h1);
        run(9);
        chk("defer_pending", 32'(pending), 32'h1);
        cycle();
        chk("defer_applied", 32'(pending), 32'h0);
        run(6); clr_acc(); run(12);
        chk("p2_cs", 32'(cs_cnt), 32'd4);

        // Center mode P=4, duty {5,10,3,2}
        period_in = W'(4); center_in = 1'b1; set_duty(5, 10, 3, 2);
        load = 1'b1; cycle(); load = 1'b0;
        run(15); clr_acc(); run(16);
        chk("ctr_ch0_hi", 32'(hi_cnt[0]), 32'd6);
        chk("ctr_ch1_hi", 32'(hi_cnt[1]), 32'd10);
        chk("ctr_ch2_hi", 32'(hi_cnt[2]), 32'd16);
        chk("ctr_cs", 32'(cs_cnt), 32'd4 / 2);

        // Center P=1 then P=0
        period_in = W'(1); set_duty(0, 1, 1, 2);
        load = 1'b1; cycle(); load = 1'b0;
        run(12); clr_acc(); run(8);
        chk("ctr1_ch1_hi", 32'(hi_cnt[1]), 32'd4);
        chk("ctr1_cs", 32'(cs_cnt), 32'd4);
        period_in = W'(0);
        load = 1'b1; cycle(); load = 1'b0;
        run(6); clr_acc(); run(8);
        chk("ctr0_cs", 32'(cs_cnt), 32'd8);
        chk("ctr0_ch1_hi", 32'(hi_cnt[1]), 32'd8);

        // Async reset mid-period with a pending load
        period_in = W'(9); center_in = 1'b0; set_duty(5, 10, 3, 7);
        load = 1'b1; cycle(); load = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'h0);
        chk("arst_cs", 32'(cycle_start), 32'h0);
        chk("arst_pending", 32'(pending), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(4); clr_acc(); run(20);
        chk("arst_hi", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);
        chk("arst_cs_cnt", 32'(cs_cnt), 32'd0);

`ifdef PWM_DEADTIME_EN
        // Dead time 3 on edge P=9, duty 5
        period_in = W'(9); center_in = 1'b0; set_duty(0, 0, 0, 5);
        load = 1'b1; cycle(); load = 1'b0;
        en = 1'b0; cycle(); en = 1'b1;
        dt_in = DT_W'(3); pwm_chk_en = 1'b0;
        run(20); clr_acc(); run(40);
        chk("dt_hi", 32'(hi_cnt[0]), 32'd8);
        chk("dt_lo", 32'(n_cnt), 32'd8);
        chk("dt_both_low", 32'(both_low), 32'd24);
        dt_in = '0;
        run(12); pwm_chk_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("dt0_compl", 32'(pwm_n_out), 32'(~pwm_out));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Parametrised, multi-channel successor to the team's 11-bit single-channel PWM.
- One shared period counter drives NCH comparators.
- Counter length is programmable; edge-aligned and center-aligned modes are supported.
- Duty, period and mode updates are glitch-free: shadow registers are applied only at period boundaries. Sits between the motor/control loop and the drive pins.

Parameters:
- W, 11: counter, period and duty width.
- NCH, 4: number of PWM channels.
- DT_W, 6: dead-time count width (used only with PWM_DEADTIME_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  run enable; low holds counter and outputs idle
- load  in  1  one-cycle strobe; captures period_in, duty_in, center_in into shadow
- period_in  in  W  period value P
- duty_in  in  NCH*W  duty per channel; channel i at bits [i*W +: W]
- center_in  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  NCH  PWM outputs, registered
- cycle_start  out  1  one-cycle pulse aligned with the first pwm_out cycle of each period
- pending  out  1  shadow loaded but not yet applied
- dt_in  in  DT_W  dead-time cycles (PWM_DEADTIME_EN only)
- pwm_n_out  out  NCH  complementary outputs (PWM_DEADTIME_EN only)

Behaviour:
- Reset values:
  - cnt = 0, dir = up.
  - Active and shadow registers: period = 2^W-1, duty = 0, center = 0.
  - pending = 0; pwm_out, pwm_n_out, cycle_start = 0.
  - Reset mid-period abandons the period immediately.
- Edge mode counter sequence: 0,1..P,0…
  - Period length is P+1 cycles.
  - Boundary tick: cnt == P.
- Center mode counter sequence: 0,1..P,P-1..1,0…
  - Period length is 2P cycles; P=0 holds at 0 with a tick every cycle.
  - Boundary tick: the cycle whose next cnt is 0, i.e. (dir==down && cnt==1) or (dir==up && cnt==P && P<=1).
  - Direction flips to down at cnt == P.
- Compare: raw[i] = (cnt < duty[i]), unsigned.
  - duty = 0 gives 0%; duty > P gives 100%.
  - Center mode high time is 2*duty-1 cycles for 1 ≤ duty ≤ P.
- Latency: pwm_out = raw registered, 1 cycle after cnt.
  - cycle_start is registered from (en && cnt == 0 && dir == up), so it is coincident with pwm_out for count 0.
- Shadow update:
  - load captures inputs into shadow and sets pending = 1.
  - On a boundary tick with pending = 1 and load = 0: active <= shadow, pending <= 0, next cnt = 0, dir = up. A mode change takes effect here.
  - load on the same cycle as a boundary tick: shadow updates, pending stays 1, apply is deferred to the next boundary.
  - Back-to-back loads before a boundary: the last one wins.
- en low:
  - cnt = 0, dir = up, pwm_out = 0, cycle_start = 0.
  - If pending, shadow is applied the next cycle (no boundary wait).
  - On en rising, the period starts at cnt 0 in the same cycle.
- Period shrink: because changes apply only at a boundary, cnt never exceeds the active P; no wrap-around corruption.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - Adds dt_in and pwm_n_out, and one dead-time unit per channel.
  - On any raw[i] edge, both pwm_out[i] and pwm_n_out[i] go low for dt_in cycles; then the newly active side goes high.
  - A raw edge during dead time restarts the timer.
  - dt_in = 0: pwm_n_out = ~pwm_out.
  - en low forces both sides low.
  - Adds 1 cycle latency to pwm_out and cycle_start.
- Undefined: no dt_in or pwm_n_out ports; latency as above.

Decomposition:
- Package pwm_pkg: typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}; typedef cnt_dir_e {DIR_UP, DIR_DOWN}; localparam PWM_W_DEF = 11.
- Sub-module pwm_deadtime: one channel's timer plus high/low output registers; instantiated NCH times in a generate loop under the macro.
- Counter, shadow logic and comparators stay in the top module.

Test Plan:
- Edge mode, P=9, duty={0,3,10,5}, en=1 → per 10-cycle period: ch0 always 0, ch1 high 3 cycles, ch2 always 1, ch3 high 5 cycles; cycle_start every 10 cycles.
- Center mode, P=4, duty[0]=2 → cnt 0,1,2,3,4,3,2,1 repeating; pwm_out[0] high 3 of 8 cycles (cnt 0,1 and the down-count 1); cycle_start every 8 cycles.
- Shadow timing: load duty[0]=7 mid-period → pending=1, old duty holds to the boundary, new duty from the next cnt 0, pending clears.
- Load on the boundary-tick cycle → not applied this boundary; applied one period later. P 9 → 2 mid-period: no count above 9 then 2.
- en low with pending → applied next cycle, outputs 0. Async reset mid-period → all outputs 0 immediately, period = 2^W-1, duty = 0.
- PWM_DEADTIME_EN, dt_in=3, edge P=9, duty=5 → each transition shows a 3-cycle window with both outputs low; dt_in=0 → exact complements.
